// File: rtl/mmio_port_responder_if.sv
// Bus strobes plus TX/RX stream handshakes of the MMIO port responder.
// The bidirectional data pins stay a module port so the tristate resolves at the pin.
interface mmio_port_responder_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  cs_input;
  logic                  we;
  logic                  oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data_in;
  logic                  rx_valid_in;
  logic                  rx_ready_out;

  modport slave (
    input  addr, cs_input, we, oe, tx_ready, rx_data_in, rx_valid_in,
    output tx_data, tx_valid, rx_ready_out
  );

  modport master (
    output addr, cs_input, we, oe, tx_ready, rx_data_in, rx_valid_in,
    input  tx_data, tx_valid, rx_ready_out
  );
endinterface

// File: rtl/mmio_port_responder.sv
// Four-word MMIO window: TXDATA feeds a FIFO to a valid/ready sink, STATUS, a
// one-entry RX holding register and SCRATCH; reads return one cycle after sampling.
module mmio_port_responder #(
  parameter int                    ADDR_WIDTH = 14,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h3F00,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire  [DATA_WIDTH-1:0] data,
  mmio_port_responder_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_RXDATA  = 2'd2;
  localparam logic [1:0] OFF_SCRATCH = 2'd3;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  rx_full_q, rx_full_d;
  logic                  drv_q, drv_d;
  logic [DATA_WIDTH-1:0] rx_hold_q, rx_hold_d;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;

  logic                  hit, wr_acc, rd_acc;
  logic [1:0]            offset;
  logic                  tx_empty, tx_full;
  logic                  push_req, push, pop, capture;
  logic [DATA_WIDTH-1:0] status;

  assign hit      = bus.cs_input && (bus.addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
  assign offset   = bus.addr[1:0];
  assign wr_acc   = hit && bus.we;
  assign rd_acc   = hit && !bus.we && bus.oe;
  assign tx_empty = (count_q == '0);
  assign tx_full  = (count_q == FULL_COUNT);
  assign pop      = !tx_empty && bus.tx_ready;
  assign push_req = wr_acc && (offset == OFF_TXDATA);
  // A full FIFO still takes the write when the sink drains its head this cycle.
  assign push     = push_req && (!tx_full || pop);
  assign capture  = bus.rx_valid_in && !rx_full_q;

  always_comb begin
    status    = '0;
    status[3:0] = 4'(count_q);
    status[4] = tx_empty;
    status[5] = tx_full;
    status[6] = rx_full_q;
    status[7] = ovf_q;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d     = ovf_q;
    rx_full_d = rx_full_q;
    rx_hold_d = rx_hold_q;
    scratch_d = scratch_q;
    rd_d      = rd_q;
    drv_d     = rd_acc;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push_req && !push) ovf_d = 1'b1;
    if (wr_acc && (offset == OFF_STATUS) && data[7]) ovf_d = 1'b0;
    if (wr_acc && (offset == OFF_SCRATCH)) scratch_d = data;

    if (capture) begin
      rx_full_d = 1'b1;
      rx_hold_d = bus.rx_data_in;
    end else if (rd_acc && (offset == OFF_RXDATA)) begin
      rx_full_d = 1'b0;
    end

    if (rd_acc) begin
      unique case (offset)
        OFF_TXDATA:  rd_d = '0;
        OFF_STATUS:  rd_d = status;
        OFF_RXDATA:  rd_d = rx_full_q ? rx_hold_q : '0;
        OFF_SCRATCH: rd_d = scratch_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rx_full_q <= 1'b0;
      rx_hold_q <= '0;
      scratch_q <= '0;
      rd_q      <= '0;
      drv_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rx_full_q <= rx_full_d;
      rx_hold_q <= rx_hold_d;
      scratch_q <= scratch_d;
      rd_q      <= rd_d;
      drv_q     <= drv_d;
    end
  end

  // NOTE: the storage array has no reset; the cleared count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  assign data             = drv_q ? rd_q : 'z;
  assign bus.tx_valid     = !tx_empty;
  assign bus.tx_data      = mem_q[rd_ptr_q];
  assign bus.rx_ready_out = !rx_full_q;
endmodule

// File: tb/tb_mmio_port_responder.sv
// Random and directed bus traffic against a queue-based reference model; monitors
// compare read data, sink words and handshake flags from scoreboard queues.
module tb_mmio_port_responder;
  localparam int             AW    = 14;
  localparam int             DW    = 16;
  localparam int             DEPTH = 4;
  localparam logic [AW-1:0]  BASE  = 14'h3F00;
  localparam logic [DW-1:0]  IDLE  = '1;

  typedef struct {
    logic [DW-1:0] val;
    int            cyc;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  tri1 [DW-1:0]  data;
  logic          cpu_drv;
  logic [DW-1:0] cpu_wdata;

  assign data = cpu_drv ? cpu_wdata : 'z;

  mmio_port_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  mmio_port_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_fifo[$];
  logic [DW-1:0] tx_exp[$];
  rd_exp_t       rd_exp[$];
  bit            m_ovf;
  bit            m_rx_full;
  logic [DW-1:0] m_rx_hold;
  logic [DW-1:0] m_scratch;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit in_reset = 1'b1;
  bit last_rd  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_fifo.delete();
    tx_exp.delete();
    rd_exp.delete();
    m_ovf     = 1'b0;
    m_rx_full = 1'b0;
    m_rx_hold = '0;
    m_scratch = '0;
  endfunction

  // One clock edge of the block, from its register-level rules.
  function automatic void model_step();
    logic          hit, wr, rd;
    logic [1:0]    off;
    logic [DW-1:0] w, status;
    bit            pop;
    rd_exp_t       e;
    hit = bus_if.cs_input && ((bus_if.addr >> 2) == (BASE >> 2));
    wr  = hit && bus_if.we;
    rd  = hit && !bus_if.we && bus_if.oe;
    off = bus_if.addr[1:0];
    w   = cpu_wdata;
    pop = (m_fifo.size() > 0) && bus_if.tx_ready;
    status = {8'h00, m_ovf, m_rx_full, m_fifo.size() == DEPTH, m_fifo.size() == 0,
              4'(m_fifo.size())};
    if (rd) begin
      case (off)
        2'd0: e.val = '0;
        2'd1: e.val = status;
        2'd2: e.val = m_rx_full ? m_rx_hold : '0;
        default: e.val = m_scratch;
      endcase
      e.cyc = cyc;
      rd_exp.push_back(e);
    end
    if (wr) begin
      case (off)
        2'd0: begin
          if (m_fifo.size() < DEPTH || pop) begin
            m_fifo.push_back(w);
            tx_exp.push_back(w);
          end else begin
            m_ovf = 1'b1;
          end
        end
        2'd1: if (w[7]) m_ovf = 1'b0;
        2'd3: m_scratch = w;
        default: ;
      endcase
    end
    if (pop) void'(m_fifo.pop_front());
    if (!m_rx_full) begin
      if (bus_if.rx_valid_in) begin
        m_rx_full = 1'b1;
        m_rx_hold = bus_if.rx_data_in;
      end
    end else if (rd && off == 2'd2) begin
      m_rx_full = 1'b0;
    end
  endfunction

  // Read data monitor: whenever the responder drives the bus, pop and compare.
  always @(negedge clk) begin : bus_mon
    rd_exp_t e;
    if (!in_reset && !cpu_drv) begin
      if (data !== IDLE) begin
        if (rd_exp.size() == 0) begin
          check("bus_spurious_drive", data, IDLE);
        end else begin
          e = rd_exp.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_data", data, e.val);
        end
      end else if (rd_exp.size() > 0 && rd_exp[0].cyc <= cyc) begin
        e = rd_exp.pop_front();
        check("rd_missing", data, e.val);
      end
    end
  end

  // Stream monitor: sink handshakes and flag levels.
  always @(negedge clk) begin : stream_mon
    if (!in_reset) begin
      check("tx_valid", bus_if.tx_valid, m_fifo.size() != 0);
      check("rx_ready_out", bus_if.rx_ready_out, !m_rx_full);
      if (bus_if.tx_valid && bus_if.tx_ready) begin
        if (tx_exp.size() == 0) check("tx_spurious", bus_if.tx_valid, 1'b0);
        else check("tx_data", bus_if.tx_data, tx_exp.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!reset) model_step();
    #1;
  endtask

  task automatic set_idle();
    bus_if.cs_input = 1'b0;
    bus_if.we       = 1'b0;
    bus_if.oe       = 1'b0;
    cpu_drv         = 1'b0;
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) step();
    last_rd = 1'b0;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (last_rd) idle(1);
    bus_if.addr     = a;
    bus_if.cs_input = 1'b1;
    bus_if.we       = 1'b1;
    bus_if.oe       = 1'($urandom_range(0, 1));
    cpu_wdata       = d;
    cpu_drv         = 1'b1;
    step();
    set_idle();
    last_rd = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a);
    bus_if.addr     = a;
    bus_if.cs_input = 1'b1;
    bus_if.we       = 1'b0;
    bus_if.oe       = 1'b1;
    step();
    set_idle();
    last_rd = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            op;

    reset                = 1'b1;
    cpu_wdata            = '0;
    bus_if.addr          = '0;
    bus_if.tx_ready      = 1'b0;
    bus_if.rx_valid_in   = 1'b0;
    bus_if.rx_data_in    = '0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx_valid", bus_if.tx_valid, 1'b0);
    check("reset_rx_ready", bus_if.rx_ready_out, 1'b1);
    check("reset_data_z", data, IDLE);
    reset    = 1'b0;
    in_reset = 1'b0;

    // Status after reset
    bus_read(BASE + 14'd1);
    idle(2);

    // Fill, overflow, drain, clear ovf
    bus_if.tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) bus_write(BASE, DW'(i * 'h1111));
    bus_read(BASE + 14'd1);
    bus_if.tx_ready = 1'b1;
    idle(6);
    bus_read(BASE + 14'd1);
    bus_write(BASE + 14'd1, 16'h0080);
    bus_read(BASE + 14'd1);
    idle(1);

    // Push into a full FIFO while its head drains
    bus_if.tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) bus_write(BASE, DW'(16'h2001 + i));
    bus_if.tx_ready = 1'b1;
    bus_write(BASE, 16'hABCD);
    bus_read(BASE + 14'd1);
    idle(7);

    // RX holding register
    bus_if.rx_data_in  = 16'hBEEF;
    bus_if.rx_valid_in = 1'b1;
    idle(1);
    bus_if.rx_data_in  = 16'h1234;
    idle(2);
    bus_read(BASE + 14'd1);
    bus_read(BASE + 14'd2);
    bus_read(BASE + 14'd2);
    bus_if.rx_valid_in = 1'b0;
    bus_read(BASE + 14'd2);
    bus_read(BASE + 14'd2);

    // Scratch, back-to-back reads, out-of-window access
    bus_write(BASE + 14'd3, 16'h5A5A);
    bus_read(BASE + 14'd3);
    bus_read(BASE + 14'd1);
    bus_read(BASE + 14'd3);
    bus_write(BASE + 14'd4, 16'h7777);
    bus_read(BASE + 14'd4);
    bus_read(BASE + 14'd3);
    idle(2);

    // Reset with two words queued and a read in flight
    bus_if.tx_ready = 1'b0;
    bus_write(BASE, 16'h0AA1);
    bus_write(BASE, 16'h0BB2);
    bus_read(BASE + 14'd1);
    #2;
    in_reset = 1'b1;
    reset    = 1'b1;
    #1;
    check("midrst_data_z", data, IDLE);
    check("midrst_tx_valid", bus_if.tx_valid, 1'b0);
    check("midrst_rx_ready", bus_if.rx_ready_out, 1'b1);
    model_reset();
    @(posedge clk);
    cyc++;
    #1;
    reset    = 1'b0;
    in_reset = 1'b0;
    last_rd  = 1'b0;
    bus_read(BASE + 14'd1);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus_if.tx_ready    = 1'($urandom_range(0, 1));
      bus_if.rx_valid_in = ($urandom_range(0, 3) == 0);
      bus_if.rx_data_in  = DW'($urandom_range(0, 16'hFFFE));
      a = BASE + AW'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) != 0) ? BASE + 14'd4 : BASE - 14'd1;
      d  = DW'($urandom_range(0, 16'hFFFE));
      op = $urandom_range(0, 9);
      if (op < 4) begin
        bus_write(a, d);
      end else if (op < 8) begin
        bus_read(a);
      end else if (op == 8) begin
        bus_if.addr     = a;
        bus_if.cs_input = 1'($urandom_range(0, 1));
        bus_if.we       = 1'b0;
        bus_if.oe       = 1'b0;
        step();
        set_idle();
        last_rd = 1'b0;
      end else begin
        idle(1);
      end
    end

    // Drain and confirm every expected response was seen
    bus_if.rx_valid_in = 1'b0;
    bus_if.tx_ready    = 1'b1;
    bus_read(BASE + 14'd1);
    idle(DEPTH + 6);
    @(negedge clk);
    #1;
    check("tx_exp_drained", tx_exp.size(), 0);
    check("rd_exp_drained", rd_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mmio_port_responder.md
# mmio_port_responder

Memory-mapped I/O responder on the CPU's synchronous single-port memory bus (MAR address, bidirectional data, cs/we/oe strobes). It occupies a 4-word window at BASE_ADDR alongside the RAM. CPU writes to the window feed a TX FIFO that drains to a valid/ready sink. CPU reads return status, scratch, or a one-entry RX holding register filled from a valid/ready source.

## Interface
- ADDR_WIDTH, 14, bus address width
- DATA_WIDTH, 16, bus and stream data width
- BASE_ADDR, 'h3F00, window base; must be 4-aligned
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, 2..8
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  asynchronous, active-high
- addr  in  ADDR_WIDTH  bus address
- data  inout  DATA_WIDTH  bus data; high-Z unless this block is driving
- cs_input  in  1  chip select
- we  in  1  write enable
- oe  in  1  output enable
- tx_data  out  DATA_WIDTH  FIFO head
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  sink accepts head
- rx_data_in  in  DATA_WIDTH  source data
- rx_valid_in  in  1  source data valid
- rx_ready_out  out  1  holding register empty

## Operation
- Hit: cs_input=1 and addr[ADDR_WIDTH-1:2]==BASE_ADDR[ADDR_WIDTH-1:2]; offset = addr[1:0]. A non-hit has no effect and never drives data.
- Write access: hit, we=1 (oe ignored). Read access: hit, we=0, oe=1.
- Offset 0 TXDATA: write pushes data into the FIFO. A write when full is dropped and sets sticky ovf. Reads return 0.
- Offset 1 STATUS (reads): [3:0] tx_count, [4] tx_empty, [5] tx_full, [6] rx_full, [7] ovf, others 0. Writing with bit 7 = 1 clears ovf; other bits are ignored.
- Offset 2 RXDATA: a read returns the holding register and clears rx_full; a read when empty returns 0. Writes are ignored.
- Offset 3 SCRATCH: full-width read/write register.
- TX FIFO: circular buffer with rd_ptr/wr_ptr wrapping at FIFO_DEPTH and count 0..FIFO_DEPTH.
  - tx_valid = (count != 0); tx_data = mem[rd_ptr].
  - Pop on tx_valid & tx_ready.
- Push and pop in the same cycle:
  - when full: both occur, count unchanged, ovf not set;
  - when empty: the push occurs and the pop cannot, because tx_valid was 0.
- RX: rx_ready_out = !rx_full. On rx_valid_in & rx_ready_out, capture rx_data_in and set rx_full. An RXDATA read and a capture cannot coincide on a full register; on an empty register the read returns 0 and the capture proceeds.
- Reset values:
  - tx_valid=0, rx_ready_out=1, data high-Z;
  - count, pointers, ovf, rx_full, SCRATCH, and the read register all 0.
  - FIFO contents need not be cleared.
- Reset asserted mid-transfer releases data and empties both paths immediately (asynchronous). The access in progress is lost.

## Timing
- Write: takes effect at the posedge where the access is sampled. STATUS reflects it on the following cycle.
- Read: latency 1.
  - At posedge E, a sampled read access loads rd_q with the register value as it stood before E and sets drv=1.
  - data = drv ? rd_q : 'z. The CPU captures at posedge E+1.
  - drv clears at E+1 unless another read is sampled at E+1. Back-to-back reads give one result per cycle.
- Side effects of a read (RXDATA pop) occur at E.
- STATUS read at E reports pre-E state, even if a push or pop also occurs at E.
- tx_valid/tx_data update the cycle after a push into an empty FIFO. Minimum push-to-sink latency is 1 cycle.
- rx_ready_out drops the cycle after a capture and rises the cycle after an RXDATA pop.

## Test plan
- Reset, then read STATUS → data 'h0010 one cycle later. tx_valid=0, rx_ready_out=1, and data is Z whenever no read is in flight.
- With tx_ready=0, write 'h1111..'h5555 to TXDATA (FIFO_DEPTH=4) → STATUS 'h00A4. Raise tx_ready → sink sees 'h1111..'h4444 in order, one per cycle. STATUS then reads 'h0090; write STATUS 'h0080 → STATUS 'h0010.
- Hold the FIFO full with tx_ready=1 and push 'hABCD in the same cycle → count stays 4, ovf=0, and 'hABCD leaves the FIFO as the 5th word.
- Source offers 'hBEEF → rx_ready_out=0 next cycle, STATUS bit 6=1. A second offer 'h1234 is not accepted. RXDATA read returns 'hBEEF, then 'h1234 is captured. A read of RXDATA when empty returns 0.
- Write SCRATCH 'h5A5A, then read addresses BASE+3, BASE+1, BASE+3 back-to-back → 'h5A5A, STATUS, 'h5A5A on consecutive cycles. Access to address BASE+4 → no drive, no state change.
- Assert reset with 2 words queued and a read in flight → data Z and tx_valid=0 immediately. After release, STATUS reads 'h0010.
